// File: rtl/hs32_memarb_pkg.sv
// Shared types and constants for the hs32 N-channel memory arbiter.
package hs32_memarb_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBusy = 2'd1,
        ArbDone = 2'd2
    } arb_state_e;

    localparam int unsigned ArbFixed = 0;
    localparam int unsigned ArbRr    = 1;

    localparam int unsigned TimeoutW = 16;

    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hs32_memarb_if.sv
// External valid/ready memory bus between the arbiter (master) and memory (slave).
interface hs32_memarb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          valid;
    logic          ready;

    modport master (output addr, rw, dout, valid, input din, ready);
    modport slave  (input addr, rw, dout, valid, output din, ready);
endinterface

// File: rtl/hs32_arb_pick.sv
// Combinational winner select: fixed (lowest index) or round-robin from ptr.
module hs32_arb_pick #(
    parameter int unsigned NCH = 2
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    input  logic                   mode,
    output logic [NCH-1:0]         onehot,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   any
);
    localparam int unsigned PW = $clog2(NCH);

    int unsigned   k;
    logic [PW-1:0] kk;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        kk     = '0;
        // Scan order starts at ptr in round-robin mode, at 0 otherwise.
        for (int unsigned i = 0; i < NCH; i++) begin
            k  = mode ? (32'(ptr) + i) % NCH : i;
            kk = PW'(k);
            if (!any && req[kk]) begin
                any        = 1'b1;
                onehot[kk] = 1'b1;
                idx        = kk;
            end
        end
    end

endmodule

// File: rtl/hs32_memarb.sv
// N-channel arbiter onto a single valid/ready memory bus, with optional
// bus-timeout watchdog that completes hung transactions with err.
module hs32_memarb
    import hs32_memarb_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned MODE    = 0,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic              i_clk,
    input  logic              reset,
    hs32_memarb_if.master     bus,
    input  logic [NCH*AW-1:0] addr_ch,
    input  logic [NCH*DW-1:0] dtw_ch,
    input  logic [NCH-1:0]    rw_ch,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    rdy,
    output logic [DW-1:0]     dtr,
    output logic              err,
    output logic [NCH-1:0]    gnt
);
    localparam int unsigned PW = $clog2(NCH);
    localparam bit ToEn = (TIMEOUT > 0);
    // Expiry fires in the BUSY cycle whose increment would reach TIMEOUT.
    localparam logic [TimeoutW-1:0] ToLast = TimeoutW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e          state_q;
    logic [NCH-1:0]      gnt_q;
    logic [NCH-1:0]      rdy_q;
    logic [PW-1:0]       gidx_q;
    logic [PW-1:0]       ptr_q;
    logic [TimeoutW-1:0] cnt_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       dout_q;
    logic [DW-1:0]       dtr_q;
    logic                rw_q;
    logic                valid_q;
    logic                err_q;

    logic [AW-1:0]  ch_addr [NCH];
    logic [DW-1:0]  ch_dtw  [NCH];
    logic [NCH-1:0] win_onehot;
    logic [PW-1:0]  win_idx;
    logic           win_any;

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign ch_addr[c] = addr_ch[c*AW +: AW];
        assign ch_dtw[c]  = dtw_ch[c*DW +: DW];
    end

    hs32_arb_pick #(
        .NCH (NCH)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .mode   (MODE == ArbRr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q <= ArbIdle;
            gnt_q   <= '0;
            rdy_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            dtr_q   <= '0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ArbIdle: begin
                    if (win_any) begin
                        gnt_q   <= win_onehot;
                        gidx_q  <= win_idx;
                        addr_q  <= ch_addr[win_idx];
                        dout_q  <= ch_dtw[win_idx];
                        rw_q    <= rw_ch[win_idx];
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ArbBusy;
                    end
                end
                ArbBusy: begin
                    // ready takes precedence over a simultaneous expiry.
                    if (bus.ready) begin
                        if (!rw_q) begin
                            dtr_q <= bus.din;
                        end
                        valid_q <= 1'b0;
                        rdy_q   <= gnt_q;
                        state_q <= ArbDone;
                    end else begin
                        cnt_q <= cnt_q + TimeoutW'(1);
                        if (ToEn && cnt_q == ToLast) begin
                            valid_q <= 1'b0;
                            err_q   <= 1'b1;
                            dtr_q   <= '0;
                            rdy_q   <= gnt_q;
                            state_q <= ArbDone;
                        end
                    end
                end
                ArbDone: begin
                    rdy_q <= '0;
                    gnt_q <= '0;
                    err_q <= 1'b0;
                    if (MODE == ArbRr) begin
                        ptr_q <= PW'(wrap_inc(32'(gidx_q), NCH));
                    end
                    state_q <= ArbIdle;
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

    assign bus.addr  = addr_q;
    assign bus.rw    = rw_q;
    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign rdy       = rdy_q;
    assign dtr       = dtr_q;
    assign err       = err_q;
    assign gnt       = gnt_q;

endmodule

// File: tb/tb_hs32_memarb.sv
// Directed bench: fixed-priority/timeout instance driven from a cycle table,
// round-robin instance exercised by hand-written multi-cycle sequences.
module tb_hs32_memarb;

    localparam logic [31:0] A0 = 32'h40;
    localparam logic [31:0] A1 = 32'h100;
    localparam logic [31:0] D0 = 32'h55AA;
    localparam logic [31:0] D1 = 32'h1111;

    typedef struct {
        logic [1:0]  req;
        logic        ready;
        logic [31:0] din;
        logic        valid;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] dout;
        logic [1:0]  rdy;
        logic        err;
        logic [31:0] dtr;
        logic [1:0]  gnt;
    } vec_t;

    logic clk;
    logic rst0;
    logic rst1;

    // Instance 0: NCH=2, fixed priority, TIMEOUT=4
    logic [63:0] addr_ch0;
    logic [63:0] dtw_ch0;
    logic [1:0]  rw_ch0;
    logic [1:0]  req0;
    logic [1:0]  rdy0;
    logic [31:0] dtr0;
    logic        err0;
    logic [1:0]  gnt0;

    // Instance 1: NCH=3, round-robin, no watchdog
    logic [95:0] addr_ch1;
    logic [95:0] dtw_ch1;
    logic [2:0]  rw_ch1;
    logic [2:0]  req1;
    logic [2:0]  rdy1;
    logic [31:0] dtr1;
    logic        err1;
    logic [2:0]  gnt1;

    int n_checks = 0;
    int n_fail   = 0;

    hs32_memarb_if #(.AW(32), .DW(32)) bus0 ();
    hs32_memarb_if #(.AW(32), .DW(32)) bus1 ();

    hs32_memarb #(
        .NCH     (2),
        .MODE    (0),
        .TIMEOUT (4),
        .AW      (32),
        .DW      (32)
    ) u_dut0 (
        .i_clk   (clk),
        .reset   (rst0),
        .bus     (bus0),
        .addr_ch (addr_ch0),
        .dtw_ch  (dtw_ch0),
        .rw_ch   (rw_ch0),
        .req     (req0),
        .rdy     (rdy0),
        .dtr     (dtr0),
        .err     (err0),
        .gnt     (gnt0)
    );

    hs32_memarb #(
        .NCH     (3),
        .MODE    (1),
        .TIMEOUT (0),
        .AW      (32),
        .DW      (32)
    ) u_dut1 (
        .i_clk   (clk),
        .reset   (rst1),
        .bus     (bus1),
        .addr_ch (addr_ch1),
        .dtw_ch  (dtw_ch1),
        .rw_ch   (rw_ch1),
        .req     (req1),
        .rdy     (rdy1),
        .dtr     (dtr1),
        .err     (err1),
        .gnt     (gnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t v(logic [1:0] rq, logic rd, logic [31:0] di, logic vl,
                               logic [31:0] ad, logic w, logic [31:0] dq, logic [1:0] rp,
                               logic er, logic [31:0] dt, logic [1:0] gn);
        vec_t r;
        r.req = rq; r.ready = rd; r.din = di; r.valid = vl; r.addr = ad; r.rw = w;
        r.dout = dq; r.rdy = rp; r.err = er; r.dtr = dt; r.gnt = gn;
        return r;
    endfunction

    function automatic int dec3(logic [2:0] r);
        case (r)
            3'b000:  return -1;
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 9;
        endcase
    endfunction

    vec_t tv[$];

    initial begin
        int pulses;
        int cyc;
        int idx;
        int order[7];
        int when[7];

        // req, ready, din | valid, addr, rw, dout, rdy, err, dtr, gnt
        // single read on channel 1, ready in second BUSY cycle
        tv.push_back(v(2'b10, 0, 0,            0, 0,  0, 0,  2'b00, 0, 0,            2'b00));
        tv.push_back(v(2'b10, 0, 0,            1, A1, 0, D1, 2'b00, 0, 0,            2'b10));
        tv.push_back(v(2'b10, 1, 32'hDEADBEEF, 1, A1, 0, D1, 2'b00, 0, 0,            2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b10, 0, 32'hDEADBEEF, 2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b00, 0, 32'hDEADBEEF, 2'b00));
        // both request: channel 0 write first, then channel 1 read
        tv.push_back(v(2'b11, 0, 0,            0, A1, 0, D1, 2'b00, 0, 32'hDEADBEEF, 2'b00));
        tv.push_back(v(2'b11, 1, 32'h12345678, 1, A0, 1, D0, 2'b00, 0, 32'hDEADBEEF, 2'b01));
        tv.push_back(v(2'b10, 0, 0,            0, A0, 1, D0, 2'b01, 0, 32'hDEADBEEF, 2'b01));
        tv.push_back(v(2'b10, 0, 0,            0, A0, 1, D0, 2'b00, 0, 32'hDEADBEEF, 2'b00));
        tv.push_back(v(2'b10, 1, 32'hCAFEF00D, 1, A1, 0, D1, 2'b00, 0, 32'hDEADBEEF, 2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b10, 0, 32'hCAFEF00D, 2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b00, 0, 32'hCAFEF00D, 2'b00));
        // watchdog: ready never comes, valid high for 4 cycles
        tv.push_back(v(2'b01, 0, 0,            0, A1, 0, D1, 2'b00, 0, 32'hCAFEF00D, 2'b00));
        tv.push_back(v(2'b01, 0, 0,            1, A0, 1, D0, 2'b00, 0, 32'hCAFEF00D, 2'b01));
        tv.push_back(v(2'b01, 0, 0,            1, A0, 1, D0, 2'b00, 0, 32'hCAFEF00D, 2'b01));
        tv.push_back(v(2'b01, 0, 0,            1, A0, 1, D0, 2'b00, 0, 32'hCAFEF00D, 2'b01));
        tv.push_back(v(2'b01, 0, 32'hFFFFFFFF, 1, A0, 1, D0, 2'b00, 0, 32'hCAFEF00D, 2'b01));
        tv.push_back(v(2'b00, 0, 0,            0, A0, 1, D0, 2'b01, 1, 0,            2'b01));
        tv.push_back(v(2'b00, 0, 0,            0, A0, 1, D0, 2'b00, 0, 0,            2'b00));
        // next request after the timeout completes normally
        tv.push_back(v(2'b10, 0, 0,            0, A0, 1, D0, 2'b00, 0, 0,            2'b00));
        tv.push_back(v(2'b10, 1, 32'hA5A5A5A5, 1, A1, 0, D1, 2'b00, 0, 0,            2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b10, 0, 32'hA5A5A5A5, 2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b00, 0, 32'hA5A5A5A5, 2'b00));
        // ready lands on the expiry cycle: ready wins
        tv.push_back(v(2'b10, 0, 0,            0, A1, 0, D1, 2'b00, 0, 32'hA5A5A5A5, 2'b00));
        tv.push_back(v(2'b10, 0, 0,            1, A1, 0, D1, 2'b00, 0, 32'hA5A5A5A5, 2'b10));
        tv.push_back(v(2'b10, 0, 0,            1, A1, 0, D1, 2'b00, 0, 32'hA5A5A5A5, 2'b10));
        tv.push_back(v(2'b10, 0, 0,            1, A1, 0, D1, 2'b00, 0, 32'hA5A5A5A5, 2'b10));
        tv.push_back(v(2'b10, 1, 32'h0BADF00D, 1, A1, 0, D1, 2'b00, 0, 32'hA5A5A5A5, 2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b10, 0, 32'h0BADF00D, 2'b10));
        tv.push_back(v(2'b00, 0, 0,            0, A1, 0, D1, 2'b00, 0, 32'h0BADF00D, 2'b00));

        rst0 = 1'b1;
        rst1 = 1'b1;
        addr_ch0 = {A1, A0};
        dtw_ch0  = {D1, D0};
        rw_ch0   = 2'b01;
        req0     = 2'b00;
        addr_ch1 = {32'h1002, 32'h1001, 32'h1000};
        dtw_ch1  = '0;
        rw_ch1   = 3'b000;
        req1     = 3'b000;
        bus0.ready = 1'b0;
        bus0.din   = '0;
        bus1.ready = 1'b0;
        bus1.din   = '0;

        @(negedge clk);
        @(negedge clk);
        check("reset_state0", {bus0.valid, bus0.addr, bus0.rw, bus0.dout, rdy0, err0, dtr0, gnt0}, '0);
        check("reset_state1", {bus1.valid, bus1.addr, bus1.rw, bus1.dout, rdy1, err1, dtr1, gnt1}, '0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        foreach (tv[i]) begin
            req0       = tv[i].req;
            bus0.ready = tv[i].ready;
            bus0.din   = tv[i].din;
            check($sformatf("vec%0d", i),
                  {bus0.valid, bus0.addr, bus0.rw, bus0.dout, rdy0, err0, dtr0, gnt0},
                  {tv[i].valid, tv[i].addr, tv[i].rw, tv[i].dout, tv[i].rdy, tv[i].err,
                   tv[i].dtr, tv[i].gnt});
            @(negedge clk);
        end
        req0       = 2'b00;
        bus0.ready = 1'b0;

        // Round-robin with all requests held and immediate ready
        req1       = 3'b111;
        bus1.ready = 1'b1;
        pulses = 0;
        cyc    = 0;
        while (pulses < 7 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            idx = dec3(rdy1);
            if (idx != -1) begin
                order[pulses] = idx;
                when[pulses]  = cyc;
                pulses++;
            end
        end
        check("rr_pulse_count", 128'(pulses), 128'(7));
        for (int i = 0; i < pulses; i++) begin
            check($sformatf("rr_order%0d", i), 128'(order[i]), 128'(i % 3));
        end
        for (int i = 1; i < pulses; i++) begin
            check($sformatf("rr_spacing%0d", i), 128'(when[i] - when[i-1]), 128'(3));
        end

        // Pointer now sits at 1: next grant goes to channel 1, then reset mid-BUSY
        bus1.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rr_busy_before_reset", {bus1.valid, gnt1}, {1'b1, 3'b010});
        #2;
        rst1 = 1'b1;
        #1;
        check("reset_async_drop", {bus1.valid, gnt1, rdy1, err1}, '0);
        bus1.ready = 1'b1;
        req1       = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst1       = 1'b0;
        bus1.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no_rdy_after_reset%0d", i), {bus1.valid, rdy1, gnt1}, '0);
        end

        // Channels 0 and 2 request: pointer at 0 picks channel 0
        req1 = 3'b101;
        @(negedge clk);
        check("post_reset_grant", {gnt1, bus1.valid, bus1.addr}, {3'b001, 1'b1, 32'h1000});
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("no_watchdog", {bus1.valid, err1, rdy1}, {1'b1, 1'b0, 3'b000});
        bus1.ready = 1'b1;
        bus1.din   = 32'h77;
        @(negedge clk);
        bus1.ready = 1'b0;
        req1       = 3'b100;
        check("post_reset_done", {rdy1, err1, dtr1}, {3'b001, 1'b0, 32'h77});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hs32_memarb.md
Name: hs32_memarb

Overview:
Parametrised N-channel memory arbiter and the successor to the fixed two-channel execute/fetch arbiter in hs32_cpu. It multiplexes N requester channels onto the single external valid/ready bus. Arbitration is selectable between fixed priority and round-robin. An optional bus-timeout watchdog aborts hung transactions and flags an error to the requester.

Parameters:
NCH, 2, number of requester channels (2..8); channel 0 is highest priority in fixed mode.
MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
TIMEOUT, 0, max cycles to wait for ready while valid; 0 disables the watchdog; otherwise 1..65535.
AW, 32, address width.
DW, 32, data width.

Ports:
i_clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
addr  out  AW  external address
rw  out  1  external direction, 1 = write
din  in  DW  external read data
dout  out  DW  external write data
valid  out  1  external transaction request
ready  in  1  external completion strobe
addr_ch  in  NCH*AW  packed channel addresses; channel k at [k*AW +: AW]
dtw_ch  in  NCH*DW  packed channel write data
rw_ch  in  NCH  per-channel direction
req  in  NCH  per-channel request, level
rdy  out  NCH  per-channel one-cycle completion pulse
dtr  out  DW  read data broadcast to all channels; qualified by rdy
err  out  1  asserted with rdy when the transaction ended by timeout
gnt  out  NCH  one-hot current owner; debug and performance counters

Behaviour:
- Reset values: addr, dout, dtr = 0; rw, valid, err = 0; rdy, gnt = 0; state = IDLE; round-robin pointer = 0; timeout counter = 0.
- Requester contract: hold req, addr_ch, rw_ch, dtw_ch stable from req rising until its rdy pulse. The arbiter ignores a req that drops early.
- IDLE:
  - If any req is set, pick the winner g and register gnt = 1<<g, addr/rw/dout from channel g.
  - Set valid = 1, go to BUSY. Request-to-valid latency is 1 cycle.
- Winner selection:
  - MODE 0: lowest set index.
  - MODE 1: first set index at or after the pointer, wrapping at NCH-1 to 0.
- BUSY:
  - valid held high; addr/rw/dout held.
  - On the edge where ready=1: dtr <= din (reads only; dtr unchanged on writes), valid <= 0, go to DONE.
- DONE:
  - rdy[g] = 1 for exactly this one cycle.
  - Clear gnt. In MODE 1, pointer <= (g+1) mod NCH. Go to IDLE.
  - req is not sampled in DONE, so the requester has a cycle to drop req.
- Throughput: each transaction takes at least 3 cycles (IDLE, BUSY, DONE) when ready returns in the first BUSY cycle.
- Timeout (TIMEOUT > 0):
  - Counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When the counter reaches TIMEOUT: valid <= 0, err <= 1, dtr <= 0, go to DONE.
  - err clears on leaving DONE.
  - If ready and expiry occur in the same cycle, ready wins and err = 0.
- Simultaneous requests: exactly one grant per transaction. Losers keep req high and are served in later rounds.
- MODE 1 fairness: no channel waits more than NCH-1 transactions.
- Reset mid-transaction: all state returns to reset values immediately (async). valid drops without a ready, and no rdy pulse is issued for the abandoned transaction.
- req changing in BUSY/DONE has no effect on the current grant.

Decomposition:
- Shared header cpu/hs32_defs.vh holds:
  - state encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_DONE=2'd2;
  - mode constants ARB_FIXED=0, ARB_RR=1.
- One sub-module, hs32_arb_pick (combinational): takes req, pointer, and mode; returns one-hot and binary winner. It is reusable for the interrupt controller.
- The timeout counter and FSM stay in hs32_memarb.

Test Plan:
- Single read, NCH=2, MODE 0: req[1] with addr 0x100, ready after 2 cycles with din=0xDEADBEEF -> valid high 2 cycles at addr 0x100 with rw=0; rdy[1] pulses once; dtr=0xDEADBEEF.
- Fixed priority: req[0] (write 0x55AA to 0x40) and req[1] rise together -> channel 0 served first (dout=0x55AA, rw=1), then channel 1; rdy[0] precedes rdy[1].
- Round-robin, NCH=3, MODE 1, all req held high, ready immediate -> grant order 0,1,2,0,1,2; each rdy pulse spaced 3 cycles apart.
- Timeout, TIMEOUT=4, ready never asserted -> valid high 4 cycles then low; rdy[g] pulses with err=1 and dtr=0; next request is served normally.
- Timeout tie: ready asserted in the same cycle the counter reaches TIMEOUT -> err=0, dtr=din.
- Reset in BUSY: assert reset mid-transaction -> valid, gnt, rdy all 0 immediately; no rdy pulse afterward; a fresh req after reset is served with the pointer at 0.
